// File: rtl/div_repeated_sub_pkg.sv
// Shared definitions for the repeated-subtraction divider.
//   state_e       : control FSM encoding (IDLE, CALC, FIN)
//   DEFAULT_WIDTH : default operand/result width
package div_repeated_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/div_datapath.sv
// Datapath for the repeated-subtraction divider: the working remainder R,
// the divisor D and the quotient counter Q, together with the subtractor,
// the R>=D compare and the D==0 detect.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   loadRD                   : capture dividend into R and divisor into D
//   clearQ                   : clear the quotient counter
//   stepRD                   : R <= R - D
//   incQ                     : Q <= Q + 1
//   forceQ                   : Q <= all ones (divide-by-zero result)
//   dividend, divisor        : operands, used only with loadRD
//   geq                      : R >= D (unsigned)
//   dz                       : D == 0
//   r_val, q_val             : current R and Q
module div_datapath
  import div_repeated_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loadRD,
  input  logic             clearQ,
  input  logic             stepRD,
  input  logic             incQ,
  input  logic             forceQ,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             geq,
  output logic             dz,
  output logic [WIDTH-1:0] r_val,
  output logic [WIDTH-1:0] q_val
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   diff_ext;

  // One extra bit on the subtractor: its top bit is the borrow, so the
  // compare needs no separate comparator and cannot be fooled by wrap.
  assign diff_ext = {1'b0, r_q} - {1'b0, d_q};
  assign geq      = ~diff_ext[WIDTH];
  assign dz       = (d_q == '0);
  assign r_val    = r_q;
  assign q_val    = q_q;

  always_comb begin
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    if (loadRD) begin
      r_d = dividend;
      d_d = divisor;
    end else if (stepRD) begin
      r_d = diff_ext[WIDTH-1:0];
    end
    if (clearQ) begin
      q_d = '0;
    end else if (forceQ) begin
      q_d = '1;
    end else if (incQ) begin
      q_d = q_q + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction with a start/done handshake.
// One division at a time; start is only looked at while idle.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   start         : request a division (sampled in IDLE only)
//   dividend      : numerator, captured when start is accepted
//   divisor       : denominator, captured when start is accepted
//   busy          : high while a division is in progress
//   done          : one-cycle pulse when results are updated
//   quotient      : registered quotient (all ones on divide by zero)
//   remainder     : registered remainder (dividend on divide by zero)
//   div_by_zero   : registered zero-divisor flag
module div_repeated_sub
  import div_repeated_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q;
  logic             done_q;
  logic             dz_flag_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic             loadRD, clearQ, stepRD, incQ, forceQ;
  logic             geq, dz;
  logic [WIDTH-1:0] r_val, q_val;

  // Datapath strobes are decoded from the registered state; the datapath
  // itself gives reset priority, so a start coinciding with reset is lost.
  always_comb begin
    loadRD = (state_q == IDLE) && start;
    clearQ = loadRD;
    stepRD = (state_q == CALC) && !dz && geq;
    incQ   = stepRD;
    forceQ = (state_q == CALC) && dz;
  end

  div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .loadRD   (loadRD),
    .clearQ   (clearQ),
    .stepRD   (stepRD),
    .incQ     (incQ),
    .forceQ   (forceQ),
    .dividend (dividend),
    .divisor  (divisor),
    .geq      (geq),
    .dz       (dz),
    .r_val    (r_val),
    .q_val    (q_val)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dz_flag_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (dz) begin
            dz_flag_q <= 1'b1;
            state_q   <= FIN;
          end else if (!geq) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          quot_q  <= q_val;
          rem_q   <= r_val;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_flag_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
module tb_div_repeated_sub;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  div_repeated_sub #(.WIDTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("latency", cyc - e.acc, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Called at a negedge: drive a request accepted at the next posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input int lat, input bit expect_done);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (expect_done) begin
      e.q = eq; e.r = er; e.dz = edz; e.acc = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0BAD;
    chk("busy_after_accept", busy, 1);
  endtask

  // Returns at the negedge on which done is seen.
  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dz", div_by_zero, 0);

    // 100/7 = 14 r 2, latency 16
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 1);
    wait_done(40);
    // 5/9 = 0 r 5, latency 2; then back-to-back 12/12 = 1 r 0, latency 3
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2, 1);
    wait_done(40);
    issue(16'd12, 16'd12, 16'd1, 16'd0, 1'b0, 3, 1);
    wait_done(40);
    // 7/0: flag, quotient all ones, remainder 7, latency 2; then 9/3 clears it
    issue(16'd7, 16'd0, 16'hFFFF, 16'd7, 1'b1, 2, 1);
    wait_done(40);
    issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 5, 1);
    wait_done(40);
    // Results hold between done pulses
    repeat (3) @(negedge clock);
    chk("hold_quotient", quotient, 3);
    chk("hold_remainder", remainder, 0);

    // Worst case 65535/1
    issue(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 65537, 1);
    wait_done(66000);

    // 1000/3 = 333 r 1 with an ignored second request mid-flight
    @(negedge clock);
    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 335, 1);
    repeat (8) @(negedge clock);
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(400);
    // Request issued in the done cycle is accepted right after: 50/5 = 10 r 0
    issue(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 12, 1);
    wait_done(40);

    // Reset mid-operation aborts with no done
    @(negedge clock);
    issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 0, 0);
    repeat (18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    repeat (400) @(negedge clock);
    issue(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 5, 1);
    wait_done(40);

    // Reset and start together: start is not accepted
    @(negedge clock);
    reset = 1'b1; start = 1'b1; dividend = 16'd5; divisor = 16'd1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("reset_start_busy", busy, 0);
    repeat (12) @(negedge clock);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
